// File: rtl/eth_frame_checker_if.sv
// Bus between the RMII receive pins, the frame checker and the rx layer stack.
// master: PHY side driving dibits in; slave: the frame checker.
interface eth_frame_checker_if #(
    parameter int N = 2
);
    logic         axiiv;
    logic [N-1:0] axiid;
    logic         axiov;
    logic [N-1:0] axiod;
    logic         frame_done;
    logic         frame_ok;
    logic [2:0]   frame_err;
    logic [10:0]  byte_count;

    modport master (
        output axiiv, axiid,
        input  axiov, axiod, frame_done, frame_ok, frame_err, byte_count
    );

    modport slave (
        input  axiiv, axiid,
        output axiov, axiod, frame_done, frame_ok, frame_err, byte_count
    );
endinterface

// File: rtl/eth_frame_checker.sv
// RMII receive frame checker: strips preamble/SFD, forwards frame dibits with one cycle
// of latency, and reports CRC-32 residue, length and alignment status at end of carrier.
module eth_frame_checker #(
    parameter int N         = 2,
    parameter int MIN_PRE   = 8,
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1518
) (
    input logic                clk,
    input logic                rst,
    eth_frame_checker_if.slave bus
);
    localparam logic [31:0]  CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]  CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]  CRC_RESIDUE = 32'hDEBB_20E3;
    localparam int           PRE_W       = $clog2(MIN_PRE + 1);
    localparam int           DCNT_W      = 13;
    localparam logic [N-1:0] DIBIT_PRE   = N'(1);
    localparam logic [N-1:0] DIBIT_SFD   = N'(3);

    generate
        if (N != 2) begin : g_bad_width
            $error("eth_frame_checker: only N=2 (RMII) is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        FRAME,
        DROP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PRE_W-1:0]  pre_cnt;
    logic [31:0]       crc;
    logic [DCNT_W-1:0] dcnt;
    logic [10:0]       bytes;
    logic              pre_ok;
    logic              start_frame;
    logic              data_en;
    logic              frame_end;
    logic              crc_bad;
    logic              len_bad;
    logic              align_bad;

    // Reflected CRC-32, processing axiid[0] first.
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [N-1:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < N; i++) begin
            // NOTE: blocking '=' inside functions/always_comb so each bit step sees the
            // previous one; registered state is only ever written with '<='.
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // dcnt saturates at all-ones, so bytes tops out at 2047 with no extra clamp.
    assign bytes     = dcnt[DCNT_W-1:2];
    assign pre_ok    = (pre_cnt >= PRE_W'(MIN_PRE));
    assign crc_bad   = (crc != CRC_RESIDUE);
    assign align_bad = (dcnt[1:0] != 2'b00);
    assign len_bad   = (bytes < 11'(MIN_BYTES)) || (bytes > 11'(MAX_BYTES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_next  = state;
        start_frame = 1'b0;
        data_en     = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.axiiv) state_next = (bus.axiid == DIBIT_PRE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!bus.axiiv) begin
                    state_next = IDLE;
                end else if (bus.axiid == DIBIT_PRE) begin
                    state_next = PREAMBLE;
                end else if (bus.axiid == DIBIT_SFD && pre_ok) begin
                    state_next  = FRAME;
                    start_frame = 1'b1;
                end else begin
                    state_next = DROP;
                end
            end
            FRAME: begin
                if (bus.axiiv) begin
                    data_en = 1'b1;
                end else begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (!bus.axiiv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counting saturates at MIN_PRE; only the threshold matters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (state == IDLE) begin
            pre_cnt <= (bus.axiiv && bus.axiid == DIBIT_PRE) ? PRE_W'(1) : '0;
        end else if (state == PREAMBLE && bus.axiiv && bus.axiid == DIBIT_PRE && !pre_ok) begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc  <= CRC_INIT;
            dcnt <= '0;
        end else if (start_frame) begin
            crc  <= CRC_INIT;
            dcnt <= '0;
        end else if (data_en) begin
            crc <= crc_step(crc, bus.axiid);
            if (dcnt != '1) dcnt <= dcnt + DCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.axiov      <= 1'b0;
            bus.axiod      <= '0;
            bus.frame_done <= 1'b0;
            bus.frame_ok   <= 1'b0;
            bus.frame_err  <= 3'b000;
            bus.byte_count <= '0;
        end else begin
            bus.axiov      <= data_en;
            bus.frame_done <= frame_end;
            if (data_en) bus.axiod <= bus.axiid;
            if (frame_end) begin
                bus.frame_ok   <= !(crc_bad || len_bad || align_bad);
                bus.frame_err  <= {align_bad, len_bad, crc_bad};
                bus.byte_count <= bytes;
            end
        end
    end
endmodule

// File: tb/tb_eth_frame_checker.sv
// Scoreboard bench for eth_frame_checker: the driver queues expected dibits and frame
// status, a negedge monitor pops and compares whenever the DUT presents output.
module tb_eth_frame_checker;
    localparam int N = 2;

    typedef struct {
        string       name;
        logic        ok;
        logic [2:0]  err;
        logic [2:0]  err_mask;
        logic [10:0] bytes;
        int          dibits;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #10 clk = ~clk;

    eth_frame_checker_if #(.N(N)) bus ();

    eth_frame_checker #(
        .N         (N),
        .MIN_PRE   (8),
        .MIN_BYTES (64),
        .MAX_BYTES (1518)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [1:0] dat_q[$];
    logic [7:0] frm[$];
    int         vcount = 0;
    int         dcount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic flag_unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with nothing queued", name);
    endtask

    // Payload bytes are i mod 256; FCS is the complemented reflected CRC, low byte first.
    task automatic build_frame(input int payload, input bit flip);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        frm.delete();
        for (int i = 0; i < payload; i++) frm.push_back(8'(i));
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            b = frm[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
        if (flip) frm[10] = frm[10] ^ 8'h01;
    endtask

    task automatic send_dibit(input logic [1:0] d, input bit push);
        bus.axiiv = 1'b1;
        bus.axiid = d;
        if (push) dat_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_preamble(input int n01);
        for (int i = 0; i < n01; i++) send_dibit(2'b01, 1'b0);
        send_dibit(2'b11, 1'b0);
    endtask

    // Dibit k of the frame (LSB-first within each byte).
    function automatic logic [1:0] frame_dibit(input int k);
        logic [7:0] b;
        b = frm[k / 4];
        return b[2*(k % 4) +: 2];
    endfunction

    task automatic run_frame(input string name, input int payload, input bit flip,
                             input bit extra, input logic ok, input logic [2:0] err,
                             input logic [2:0] mask, input logic [10:0] exp_bytes,
                             input int gap);
        exp_t e;
        build_frame(payload, flip);
        e.name     = name;
        e.ok       = ok;
        e.err      = err;
        e.err_mask = mask;
        e.bytes    = exp_bytes;
        e.dibits   = int'(exp_bytes) * 4 + (extra ? 1 : 0);
        exp_q.push_back(e);
        send_preamble(31);
        for (int k = 0; k < frm.size() * 4; k++) send_dibit(frame_dibit(k), 1'b1);
        if (extra) send_dibit(2'b10, 1'b1);
        idle(gap);
    endtask

    // Monitor: compares every forwarded dibit and every frame_done against the queues.
    initial begin : monitor
        logic       prev_v;
        logic       prev_done;
        int         run_cnt;
        logic [1:0] d;
        exp_t       e;
        prev_v    = 1'b0;
        prev_done = 1'b0;
        run_cnt   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v    = 1'b0;
                prev_done = 1'b0;
                run_cnt   = 0;
            end else begin
                if (bus.axiov) begin
                    vcount++;
                    run_cnt++;
                    if (dat_q.size() == 0) flag_unexpected("axiov");
                    else begin
                        d = dat_q.pop_front();
                        check("axiod", 32'(bus.axiod), 32'(d));
                    end
                end
                if (bus.frame_done) begin
                    dcount++;
                    check("done_not_consecutive", 32'(prev_done), 0);
                    check("axiov_low_at_done", 32'(bus.axiov), 0);
                    check("axiov_high_before_done", 32'(prev_v), 1);
                    if (exp_q.size() == 0) flag_unexpected("frame_done");
                    else begin
                        e = exp_q.pop_front();
                        check({e.name, "_ok"}, 32'(bus.frame_ok), 32'(e.ok));
                        check({e.name, "_err"}, 32'(bus.frame_err & e.err_mask), 32'(e.err));
                        check({e.name, "_bytes"}, 32'(bus.byte_count), 32'(e.bytes));
                        check({e.name, "_axiov_cycles"}, run_cnt, e.dibits);
                    end
                    run_cnt = 0;
                end
                prev_v    = bus.axiov;
                prev_done = bus.frame_done;
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int v0;
        int d0;
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        #2 rst = 1'b1;
        #2;
        check("reset_axiov", 32'(bus.axiov), 0);
        check("reset_axiod", 32'(bus.axiod), 0);
        check("reset_frame_done", 32'(bus.frame_done), 0);
        check("reset_frame_ok", 32'(bus.frame_ok), 0);
        check("reset_frame_err", 32'(bus.frame_err), 0);
        check("reset_byte_count", 32'(bus.byte_count), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Minimum-length good frame, then CRC, length and alignment failures.
        run_frame("good64", 60, 1'b0, 1'b0, 1'b1, 3'b000, 3'b111, 11'd64, 3);
        run_frame("crc_flip", 60, 1'b1, 1'b0, 1'b0, 3'b001, 3'b111, 11'd64, 3);
        run_frame("short63", 59, 1'b0, 1'b0, 1'b0, 3'b010, 3'b111, 11'd63, 1);
        run_frame("long1519", 1515, 1'b0, 1'b0, 1'b0, 3'b010, 3'b111, 11'd1519, 3);
        run_frame("max1518", 1514, 1'b0, 1'b0, 1'b1, 3'b000, 3'b111, 11'd1518, 1);
        run_frame("extra_dibit", 60, 1'b0, 1'b1, 1'b0, 3'b100, 3'b100, 11'd64, 3);

        // Short preamble: six 01 dibits then 11 must be dropped silently.
        v0 = vcount;
        d0 = dcount;
        for (int i = 0; i < 6; i++) send_dibit(2'b01, 1'b0);
        send_dibit(2'b11, 1'b0);
        for (int i = 0; i < 20; i++) send_dibit(2'(i), 1'b0);
        idle(3);
        check("drop_axiov_cycles", vcount, v0);
        check("drop_frame_done", dcount, d0);

        // Reset after 100 frame dibits; the tail must not form a frame.
        build_frame(60, 1'b0);
        send_preamble(31);
        for (int k = 0; k < 100; k++) send_dibit(frame_dibit(k), 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_axiov", 32'(bus.axiov), 0);
        check("midrst_frame_done", 32'(bus.frame_done), 0);
        check("midrst_frame_ok", 32'(bus.frame_ok), 0);
        check("midrst_frame_err", 32'(bus.frame_err), 0);
        check("midrst_byte_count", 32'(bus.byte_count), 0);
        check("midrst_data_drained", dat_q.size(), 0);
        d0 = dcount;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 100; k < frm.size() * 4; k++) send_dibit(frame_dibit(k), 1'b0);
        idle(1);
        check("midrst_no_done", dcount, d0);
        run_frame("after_rst", 60, 1'b0, 1'b0, 1'b1, 3'b000, 3'b111, 11'd64, 3);

        for (int i = 0; i < 50 && (exp_q.size() != 0 || dat_q.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        check("status_queue_drained", exp_q.size(), 0);
        check("data_queue_drained", dat_q.size(), 0);
        check("frames_reported", dcount, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
